reflet_timer: RTL

Memory-mapped timer peripheral on the Reflet system bus, directly downstream of the CPU. It decodes the CPU's `addr`/`data_out`/`write_en` bus, holds a small register file with a prescaler, counter and compare value, and returns read data on a bus that is OR-combined with other peripherals. Its interrupt output connects to one bit of the CPU's `ext_int` input.

---
 rtl/reflet_timer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reflet_timer.sv
// rtl/reflet_timer.sv - memory-mapped prescaled timer with compare interrupt
//
// Purpose: bus-mapped timer. A prescaler divides clk into ticks; each tick
// advances COUNT until it equals CMP, which clears COUNT and latches pending.
// One-shot mode stops on that match; auto-reload mode keeps counting.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   enable     global enable; low freezes all timer state and blocks writes
//   addr       bus byte address
//   bus_wdata  bus write data
//   write_en   bus write strobe
//   bus_rdata  registered read data, zero when not addressed
//   irq        pending & int_en
//
// Register map (offset k at base_addr + k*(wordsize/8)):
//   0 CTRL {int_en, auto_reload, run}, 1 PRESC, 2 CMP, 3 COUNT, 4 STATUS {pending}

module reflet_timer #(
    parameter int                  wordsize  = 16,
    parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] bus_wdata,
    input  logic                write_en,
    output logic [wordsize-1:0] bus_rdata,
    output logic                irq
);

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    localparam logic [wordsize-1:0] bytes_per_word = wordsize'(wordsize / 8);
    localparam logic [wordsize-1:0] map_span       = wordsize'(5 * (wordsize / 8));

    localparam logic [2:0] reg_ctrl   = 3'd0;
    localparam logic [2:0] reg_presc  = 3'd1;
    localparam logic [2:0] reg_cmp    = 3'd2;
    localparam logic [2:0] reg_count  = 3'd3;
    localparam logic [2:0] reg_status = 3'd4;

    state_t              state_q, state_d;
    logic                auto_reload_q, auto_reload_d;
    logic                int_en_q, int_en_d;
    logic                pending_q, pending_d;
    logic [wordsize-1:0] presc_q, presc_d;
    logic [wordsize-1:0] cmp_q, cmp_d;
    logic [wordsize-1:0] count_q, count_d;
    logic [wordsize-1:0] pcnt_q, pcnt_d;
    logic [wordsize-1:0] rdata_q, rdata_d;

    logic [wordsize-1:0] offset;
    logic [2:0]          reg_idx;
    logic                hit;
    logic                wr;
    logic                tick;
    logic                match;

    // Offset is computed modulo 2^wordsize, so addresses below base wrap to
    // large values and fall out of range naturally.
    always_comb begin
        offset  = addr - base_addr;
        hit     = (offset < map_span) && ((offset % bytes_per_word) == '0);
        reg_idx = 3'(offset / bytes_per_word);
        wr      = enable && write_en && hit;
    end

    always_comb begin
        state_d       = state_q;
        auto_reload_d = auto_reload_q;
        int_en_d      = int_en_q;
        pending_d     = pending_q;
        presc_d       = presc_q;
        cmp_d         = cmp_q;
        count_d       = count_q;
        pcnt_d        = pcnt_q;
        rdata_d       = '0;
        tick          = 1'b0;
        match         = 1'b0;

        // Clear first so that a match in the same cycle re-sets pending.
        if (wr && (reg_idx == reg_status) && bus_wdata[0]) begin
            pending_d = 1'b0;
        end

        if ((state_q == COUNTING) && enable) begin
            if (pcnt_q == '0) begin
                tick   = 1'b1;
                pcnt_d = presc_q;
            end else begin
                pcnt_d = pcnt_q - wordsize'(1);
            end
            if (tick) begin
                if (count_q == cmp_q) begin
                    match     = 1'b1;
                    count_d   = '0;
                    pending_d = 1'b1;
                    if (!auto_reload_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + wordsize'(1);
                end
            end
        end

        // Bus writes come last so they override tick-driven updates of
        // COUNT and the one-shot stop of run.
        if (wr) begin
            case (reg_idx)
                reg_ctrl: begin
                    auto_reload_d = bus_wdata[1];
                    int_en_d      = bus_wdata[2];
                    if (bus_wdata[0]) begin
                        state_d = COUNTING;
                        if (state_q == IDLE) begin
                            pcnt_d = presc_q;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                reg_presc: presc_d = bus_wdata;
                reg_cmp:   cmp_d   = bus_wdata;
                reg_count: count_d = bus_wdata;
                default: ;
            endcase
        end

        // Read data reflects register values before any same-cycle write.
        if (hit) begin
            case (reg_idx)
                reg_ctrl:   rdata_d = {{(wordsize-3){1'b0}}, int_en_q, auto_reload_q,
                                       (state_q == COUNTING)};
                reg_presc:  rdata_d = presc_q;
                reg_cmp:    rdata_d = cmp_q;
                reg_count:  rdata_d = count_q;
                reg_status: rdata_d = {{(wordsize-1){1'b0}}, pending_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            auto_reload_q <= 1'b0;
            int_en_q      <= 1'b0;
            pending_q     <= 1'b0;
            presc_q       <= '0;
            cmp_q         <= '0;
            count_q       <= '0;
            pcnt_q        <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            auto_reload_q <= auto_reload_d;
            int_en_q      <= int_en_d;
            pending_q     <= pending_d;
            presc_q       <= presc_d;
            cmp_q         <= cmp_d;
            count_q       <= count_d;
            pcnt_q        <= pcnt_d;
            rdata_q       <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = pending_q & int_en_q;

endmodule
